// File: rtl/isa_pkg.sv
// Shared ISA constants and the decoded-field record used across the decode stage.
package isa_pkg;

   localparam int unsigned INST_W  = 32;
   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned ADDR_W  = 26;

   localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OPC_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OPC_W-1:0] OP_ORI  = 6'b001101;
   localparam logic [OPC_W-1:0] OP_LUI  = 6'b001111;
   localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [SHAMT_W-1:0] shamt;
      logic [FUNCT_W-1:0] funct;
      logic [ADDR_W-1:0]  addr;
      logic               is_branch;
   } fields_t;

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / decoded-entry-out handshake bundle for the decode stage.
interface decode_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [PC_W-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_shamt;
   logic [5:0]      out_funct;
   logic [XLEN-1:0] out_imm;
   logic [25:0]     out_addr;
   logic [PC_W-1:0] out_pc;
   logic            out_is_branch;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
             out_shamt, out_funct, out_imm, out_addr, out_pc, out_is_branch
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
             out_shamt, out_funct, out_imm, out_addr, out_pc, out_is_branch
   );
endinterface

// File: rtl/inst_fields.sv
// Purely combinational field extraction and immediate extension of one instruction word.
module inst_fields
   import isa_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [INST_W-1:0] inst,
   output fields_t           fields,
   output logic [XLEN-1:0]   imm
);
   logic [OPC_W-1:0] opc;

   assign opc = inst[31:26];

   always_comb begin
      fields.opcode    = opc;
      fields.rd        = inst[25:21];
      fields.rs        = (opc == OP_LUI) ? inst[25:21] : inst[20:16];
      fields.rt        = ((opc == OP_BEQ) || (opc == OP_BNE) || (opc == OP_SW)) ?
                         inst[25:21] : inst[15:11];
      fields.shamt     = inst[10:6];
      fields.funct     = inst[5:0];
      fields.addr      = inst[25:0];
      fields.is_branch = (opc == OP_BEQ) || (opc == OP_BNE);
   end

   always_comb begin
      if (opc == OP_LUI) begin
         imm = XLEN'({inst[15:0], 16'h0000});
      end else if ((opc == OP_ANDI) || (opc == OP_ORI)) begin
         imm = XLEN'(inst[15:0]);
      end else begin
         imm = {{(XLEN-16){inst[15]}}, inst[15:0]};
      end
   end
endmodule

// File: rtl/decode_stage.sv
// Single-cycle decode stage with an output register plus one skid entry for full throughput.
module decode_stage
   import isa_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   decode_stage_if.slave     bus,
   output logic [CNT_W-1:0]  dec_count
);
   typedef struct packed {
      fields_t         f;
      logic [XLEN-1:0] imm;
      logic [PC_W-1:0] pc;
   } entry_t;

   fields_t         in_fields;
   logic [XLEN-1:0] in_imm;
   entry_t          in_entry;

   entry_t          or_q, or_d, sk_q, sk_d;
   logic            or_valid_q, or_valid_d;
   logic            sk_valid_q, sk_valid_d;
   logic            in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            in_hs, out_hs;

   inst_fields #(.XLEN(XLEN)) u_fields (
      .inst   (bus.in_inst),
      .fields (in_fields),
      .imm    (in_imm)
   );

   assign in_entry = '{f: in_fields, imm: in_imm, pc: bus.in_pc};
   assign in_hs    = bus.in_valid && in_ready_q;
   assign out_hs   = or_valid_q && bus.out_ready;

   always_comb begin
      or_d       = or_q;
      sk_d       = sk_q;
      or_valid_d = or_valid_q;
      sk_valid_d = sk_valid_q;
      cnt_d      = cnt_q + CNT_W'(out_hs);
      if (flush) begin
         or_valid_d = 1'b0;
         sk_valid_d = 1'b0;
      end else if (out_hs || !or_valid_q) begin
         // in_ready is "SK empty", so an input handshake never coincides with a full SK
         if (sk_valid_q) begin
            or_d       = sk_q;
            sk_valid_d = 1'b0;
         end else if (in_hs) begin
            or_d       = in_entry;
            or_valid_d = 1'b1;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (in_hs) begin
         sk_d       = in_entry;
         sk_valid_d = 1'b1;
      end
      in_ready_d = !sk_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         or_q       <= '0;
         sk_q       <= '0;
         or_valid_q <= 1'b0;
         sk_valid_q <= 1'b0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         or_q       <= or_d;
         sk_q       <= sk_d;
         or_valid_q <= or_valid_d;
         sk_valid_q <= sk_valid_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = or_valid_q;
   assign bus.out_opcode    = or_q.f.opcode;
   assign bus.out_rd        = or_q.f.rd;
   assign bus.out_rs        = or_q.f.rs;
   assign bus.out_rt        = or_q.f.rt;
   assign bus.out_shamt     = or_q.f.shamt;
   assign bus.out_funct     = or_q.f.funct;
   assign bus.out_imm       = or_q.imm;
   assign bus.out_addr      = or_q.f.addr;
   assign bus.out_pc        = or_q.pc;
   assign bus.out_is_branch = or_q.f.is_branch;
   assign dec_count         = cnt_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of extended immediate; legal values are 32 and above.
REQ-002 SHALL have parameter PC_W, default 32: width of the program-counter sideband.
REQ-003 SHALL have parameter CNT_W, default 16: width of the decoded-instruction counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  upstream instruction present.
REQ-008 in_ready  out  1  stage can accept.
REQ-009 in_inst  in  32  raw instruction word.
REQ-010 in_pc  in  PC_W  PC of in_inst.
REQ-011 flush  in  1  discard all held and incoming instructions.
REQ-012 out_valid  out  1  decoded entry present.
REQ-013 out_ready  in  1  downstream accepts.
REQ-014 out_opcode/out_rd/out_rs/out_rt/out_shamt/out_funct  out  6/5/5/5/5/6  decoded fields.
REQ-015 out_imm  out  XLEN  extended immediate; out_addr  out  26  jump target field; out_pc  out  PC_W.
REQ-016 out_is_branch  out  1  opcode is BEQ or BNE.
REQ-017 dec_count  out  CNT_W  count of output handshakes.

Function
REQ-018 SHALL set opcode=inst[31:26], rd=inst[25:21], shamt=inst[10:6], funct=inst[5:0], addr=inst[25:0].
REQ-019 SHALL set rs=inst[25:21] when opcode is LUI (001111), otherwise inst[20:16].
REQ-020 SHALL set rt=inst[25:21] when opcode is BEQ (000100), BNE (000101) or SW (101011), otherwise inst[15:11].
REQ-021 SHALL form out_imm as follows: LUI -> inst[15:0] shifted left 16 and zero-extended; ANDI (001100) and ORI (001101) -> zero-extended; all other opcodes -> sign-extended.
REQ-022 SHALL decode in one cycle: an instruction accepted at edge N is presented on the outputs after edge N with out_valid=1.
REQ-023 SHALL hold two registered entries: output register (OR) and skid register (SK).
REQ-024 in_ready SHALL be a register output equal to "SK empty".
REQ-025 Input handshake: in_valid && in_ready; output handshake: out_valid && out_ready.
REQ-026 On an output handshake, or when OR is empty, OR SHALL load from SK if SK is full, otherwise from the input if an input handshake occurs, otherwise become empty.
REQ-027 An input accepted while OR stays occupied and not consumed SHALL go to SK.
REQ-028 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Throughput SHALL be one instruction per cycle with out_ready held high; no bubbles are allowed.
REQ-030 Order SHALL be preserved; no entry is dropped or duplicated except by flush.
REQ-031 flush SHALL empty OR and SK at the next edge; an input presented in the flush cycle is discarded; out_handshake in the flush cycle still counts; in_ready=1 after the flush edge.
REQ-032 dec_count SHALL increment by 1 per output handshake and wrap from all-ones to 0.
REQ-033 Field outputs while out_valid=0 are don't-care.

Reset
REQ-034 On rst=1 at an edge: out_valid=0, SK empty, in_ready=1, dec_count=0, all field registers 0.
REQ-035 Reset mid-transfer SHALL discard OR and SK contents; rst has priority over flush and handshakes.

Structure
REQ-036 Opcode constants (LUI, BEQ, BNE, SW, ANDI, ORI) and the decoded-entry field widths SHALL live in shared package isa_pkg.
REQ-037 Combinational field extraction SHALL be one sub-module, inst_fields, instantiated once on the input path; both registers store decoded entries.

Verification
REQ-038 Send 0x3D401234 (LUI) with out_ready=1 -> one cycle later opcode=0x0F, rs=10, out_imm=0x12340000.
REQ-039 Send 0x1064FFFC (BEQ) -> rt=3, rs=4, out_imm=0xFFFFFFFC, out_is_branch=1.
REQ-040 Send 0x34008000 (ORI) -> out_imm=0x00008000, out_is_branch=0.
REQ-041 Stream 4 instructions with out_ready=0 -> 2 accepted, in_ready=0 thereafter; raise out_ready -> all 4 emerge in order, with no bubble after the first.
REQ-042 With OR and SK full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and no entry from before the flush ever appears.
REQ-043 Use CNT_W=4 and 17 output handshakes -> dec_count=1; assert rst -> dec_count=0, out_valid=0.
